fabric_reset_sequencer: RTL and testbench
=========================================

Name: fabric_reset_sequencer

Overview:
- Receive end of the HPS reset path: accepts the HPS-to-FPGA reset (h2f_rst_n) and the fabric PLL lock, and generates staged, synchronously-released active-low resets for fabric domains.
- Sits in the top-level IO/housekeeping layer alongside the button debounce and HPS reset pulse generators.
- Also provides a debug status: FSM state, all-released flag, and a saturating count of reset events.

Parameters:
- NUM_STAGES, 3, number of fabric reset outputs, released in index order; range 1..8.
- STABLE_CYCLES, 50000, consecutive cycles both inputs must be high before the first release (1 ms at 50 MHz); must be ≥1.
- STABLE_WIDTH, 16, counter width; ceil(log2(STABLE_CYCLES+1)).
- STAGE_GAP, 16, cycles between successive stage releases; must be ≥1.
- GAP_WIDTH, 5, counter width; ceil(log2(STAGE_GAP+1)).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- h2f_rst_n  input  1  HPS-to-FPGA reset, active low, asynchronous to clk.
- pll_locked  input  1  fabric PLL lock, asynchronous to clk.
- rst_n_out  output  NUM_STAGES  staged fabric resets, active low.
- all_released  output  1  high while every stage is released (RUN state).
- seq_state  output  2  FSM state: 0 HOLD, 1 WAIT_STABLE, 2 RELEASE, 3 RUN.
- reset_events  output  8  saturating count of input-drop events.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rst_n_out = all 0; all_released = 0; seq_state = HOLD; reset_events = 0.
  - Both synchronizer chains clear to 0.
  - Deassertion of reset_n is assumed synchronized upstream.
- Synchronizers: h2f_rst_n and pll_locked each pass through a 2-flop chain. The synchronized values are h_s and p_s; ok = h_s & p_s.
- All outputs are registered. No combinational path from input to output.
- HOLD:
  - rst_n_out = 0; counters cleared.
  - Go to WAIT_STABLE when ok = 1.
- WAIT_STABLE:
  - The stable counter increments each cycle ok = 1.
  - When it reaches STABLE_CYCLES-1 with ok = 1, go to RELEASE. On the same edge, set rst_n_out[0] = 1 and clear the gap counter.
  - Net effect: rst_n_out[0] rises STABLE_CYCLES edges after the first edge on which ok = 1 is sampled.
- RELEASE:
  - The gap counter increments each cycle.
  - At STAGE_GAP-1, release the next stage and clear the counter. rst_n_out[i] rises exactly STAGE_GAP cycles after rst_n_out[i-1].
  - On the edge the last stage is released, go to RUN and set all_released = 1 on that same edge.
  - NUM_STAGES = 1: go directly from WAIT_STABLE to RUN. all_released rises together with rst_n_out[0].
- RUN: all outputs held released.
- Abort (any non-HOLD state, ok = 0 sampled):
  - Next edge: rst_n_out = all 0, all_released = 0, go to HOLD.
  - reset_events increments by 1, saturating at 255.
  - End-to-end: rst_n_out is low within 3 clk edges of the input falling.
  - A drop while in HOLD does not count.
- A glitch on ok of ≥1 synchronized cycle during WAIT_STABLE aborts and restarts the full stable count; the abort counts as an event.
- Released stages are never individually re-asserted. Assertion is always all stages together.
- seq_state reflects the registered FSM state.

Test Plan (bench uses STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3):
- Power-up: reset_n low, then high, with both inputs high from t0 → rst_n_out[0] rises 8 cycles after the first ok sample; [1] at +4; [2] at +8. all_released rises with [2]. seq_state goes 0→1→2→3. reset_events = 0.
- Drop h2f_rst_n for 1 cycle during RUN → rst_n_out = 000 within 3 edges; all_released = 0; reset_events = 1; full sequence repeats after the input restores.
- Drop pll_locked after 5 cycles of WAIT_STABLE → back to HOLD; stable count restarts from 0 (release occurs 8 cycles after restore, not 3); reset_events = 1.
- Drop an input while in RELEASE after stage 0 is released → all stages low simultaneously; stage 1 is never released; FSM returns to HOLD.
- 300 drop/restore cycles → reset_events saturates at 255 and does not wrap.
- reset_n asserted mid-RELEASE → all outputs 0 immediately (asynchronous); reset_events = 0; seq_state = HOLD.

Source files
------------

// File: rtl/fabric_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its surroundings: the two raw
// reset/lock inputs, the staged fabric resets and the debug status.
interface fabric_reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
);

    logic                  h2f_rst_n;
    logic                  pll_locked;
    logic [NUM_STAGES-1:0] rst_n_out;
    logic                  all_released;
    logic [1:0]            seq_state;
    logic [7:0]            reset_events;

    // Driver of the raw inputs, consumer of the resets and status
    modport master (
        output h2f_rst_n,
        output pll_locked,
        input  rst_n_out,
        input  all_released,
        input  seq_state,
        input  reset_events
    );

    // The sequencer itself
    modport slave (
        input  h2f_rst_n,
        input  pll_locked,
        output rst_n_out,
        output all_released,
        output seq_state,
        output reset_events
    );

endinterface

// File: rtl/fabric_reset_sequencer.sv
// Staged fabric reset release: waits for the HPS reset and PLL lock to be stable,
// then releases each fabric reset in index order, and re-asserts all on any drop.
module fabric_reset_sequencer #(
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned STABLE_WIDTH  = 16,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned GAP_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    fabric_reset_sequencer_if.slave  bus
);

    localparam int unsigned EVT_WIDTH = 8;

    localparam logic [STABLE_WIDTH-1:0] STABLE_LAST = STABLE_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [GAP_WIDTH-1:0]    GAP_LAST    = GAP_WIDTH'(STAGE_GAP - 1);
    localparam logic [EVT_WIDTH-1:0]    EVT_MAX     = '1;

    typedef enum logic [1:0] {
        HOLD        = 2'd0,
        WAIT_STABLE = 2'd1,
        RELEASE     = 2'd2,
        RUN         = 2'd3
    } seq_state_e;

    logic h_meta_q, h_sync_q;
    logic p_meta_q, p_sync_q;
    logic ok;

    seq_state_e              state_q, state_d;
    logic [STABLE_WIDTH-1:0] stable_cnt_q, stable_cnt_d;
    logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
    logic [NUM_STAGES-1:0]   rst_n_out_q, rst_n_out_d;
    logic                    all_released_q, all_released_d;
    logic [EVT_WIDTH-1:0]    reset_events_q, reset_events_d;
    logic [NUM_STAGES-1:0]   next_stage;
    logic                    abort;

    // Two-flop synchronizers for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_meta_q <= 1'b0;
            h_sync_q <= 1'b0;
            p_meta_q <= 1'b0;
            p_sync_q <= 1'b0;
        end else begin
            h_meta_q <= bus.h2f_rst_n;
            h_sync_q <= h_meta_q;
            p_meta_q <= bus.pll_locked;
            p_sync_q <= p_meta_q;
        end
    end

    assign ok = h_sync_q & p_sync_q;

    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HOLD;
            stable_cnt_q   <= '0;
            gap_cnt_q      <= '0;
            rst_n_out_q    <= '0;
            all_released_q <= 1'b0;
            reset_events_q <= '0;
        end else begin
            state_q        <= state_d;
            stable_cnt_q   <= stable_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            rst_n_out_q    <= rst_n_out_d;
            all_released_q <= all_released_d;
            reset_events_q <= reset_events_d;
        end
    end

    // Next-state logic; a drop of ok outside HOLD always wins over a pending release
    always_comb begin
        state_d        = state_q;
        stable_cnt_d   = stable_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        rst_n_out_d    = rst_n_out_q;
        all_released_d = all_released_q;
        reset_events_d = reset_events_q;
        next_stage     = (rst_n_out_q << 1) | NUM_STAGES'(1);
        abort          = (state_q != HOLD) && !ok;

        if (abort) begin
            state_d        = HOLD;
            stable_cnt_d   = '0;
            gap_cnt_d      = '0;
            rst_n_out_d    = '0;
            all_released_d = 1'b0;
            if (reset_events_q != EVT_MAX) begin
                reset_events_d = reset_events_q + EVT_WIDTH'(1);
            end
        end else begin
            unique case (state_q)
                HOLD: begin
                    stable_cnt_d   = '0;
                    gap_cnt_d      = '0;
                    rst_n_out_d    = '0;
                    all_released_d = 1'b0;
                    if (ok) begin
                        state_d = WAIT_STABLE;
                    end
                end
                WAIT_STABLE: begin
                    if (stable_cnt_q == STABLE_LAST) begin
                        stable_cnt_d = '0;
                        gap_cnt_d    = '0;
                        rst_n_out_d  = NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state_d        = RUN;
                            all_released_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        stable_cnt_d = stable_cnt_q + STABLE_WIDTH'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d   = '0;
                        rst_n_out_d = next_stage;
                        if (&next_stage) begin
                            state_d        = RUN;
                            all_released_d = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                    end
                end
                RUN: begin
                    rst_n_out_d    = '1;
                    all_released_d = 1'b1;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    assign bus.rst_n_out    = rst_n_out_q;
    assign bus.all_released = all_released_q;
    assign bus.seq_state    = state_q;
    assign bus.reset_events = reset_events_q;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Bench for fabric_reset_sequencer: elapsed-time reference model checked every
// cycle, plus directed scenarios with hand-computed edge numbers.
module tb_fabric_reset_sequencer;

    localparam int S = 8;
    localparam int G = 4;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n;

    int total = 0;
    int bad   = 0;

    fabric_reset_sequencer_if #(.NUM_STAGES(N)) bus ();

    fabric_reset_sequencer #(
        .NUM_STAGES   (N),
        .STABLE_CYCLES(S),
        .STABLE_WIDTH (4),
        .STAGE_GAP    (G),
        .GAP_WIDTH    (3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run_len = edges elapsed since the sequence started (-1 when held)
    int   run_len = -1;
    int   ev      = 0;
    logic s1      = 1'b0;
    logic s2      = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic okf;
        if (!reset_n) begin
            run_len = -1;
            ev      = 0;
            s1      = 1'b0;
            s2      = 1'b0;
        end else begin
            okf = s2;
            s2  = s1;
            s1  = bus.h2f_rst_n & bus.pll_locked;
            if (run_len >= 0) begin
                if (!okf) begin
                    run_len = -1;
                    if (ev < 255) ev++;
                end else if (run_len < 100000) begin
                    run_len++;
                end
            end else if (okf) begin
                run_len = 0;
            end
        end
    end

    function automatic int exp_out();
        int v = 0;
        for (int i = 0; i < N; i++)
            if (run_len >= S + i * G) v |= (1 << i);
        return v;
    endfunction

    function automatic int exp_state();
        if (run_len < 0) return 0;
        if (run_len < S) return 1;
        if (run_len < S + (N - 1) * G) return 2;
        return 3;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("model_rst_n_out", int'(bus.rst_n_out), exp_out());
        check("model_all_released", int'(bus.all_released), (run_len >= S + (N - 1) * G) ? 1 : 0);
        check("model_seq_state", int'(bus.seq_state), exp_state());
        check("model_reset_events", int'(bus.reset_events), ev);
    end

    task automatic do_reset(input logic h, input logic p);
        @(posedge clk); #1;
        reset_n        = 1'b0;
        bus.h2f_rst_n  = h;
        bus.pll_locked = p;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic found;
        reset_n        = 1'b1;
        bus.h2f_rst_n  = 1'b1;
        bus.pll_locked = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_out", int'(bus.rst_n_out), 0);
        check("reset_all", int'(bus.all_released), 0);
        check("reset_state", int'(bus.seq_state), 0);
        check("reset_events", int'(bus.reset_events), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Power-up: first ok sample on edge 3, stages at 11 / 15 / 19
        for (int n = 1; n <= 22; n++) begin
            step();
            case (n)
                2:  check("pu_state_e2", int'(bus.seq_state), 0);
                3:  check("pu_state_e3", int'(bus.seq_state), 1);
                10: check("pu_out_e10", int'(bus.rst_n_out), 0);
                11: begin
                    check("pu_out_e11", int'(bus.rst_n_out), 1);
                    check("pu_state_e11", int'(bus.seq_state), 2);
                end
                14: check("pu_out_e14", int'(bus.rst_n_out), 1);
                15: check("pu_out_e15", int'(bus.rst_n_out), 3);
                18: begin
                    check("pu_out_e18", int'(bus.rst_n_out), 3);
                    check("pu_all_e18", int'(bus.all_released), 0);
                end
                19: begin
                    check("pu_out_e19", int'(bus.rst_n_out), 7);
                    check("pu_all_e19", int'(bus.all_released), 1);
                    check("pu_state_e19", int'(bus.seq_state), 3);
                end
                22: check("pu_events", int'(bus.reset_events), 0);
                default: ;
            endcase
        end

        // One-cycle h2f_rst_n drop during RUN
        bus.h2f_rst_n = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n == 1) bus.h2f_rst_n = 1'b1;
            case (n)
                2: check("drop_out_e2", int'(bus.rst_n_out), 7);
                3: begin
                    check("drop_out_e3", int'(bus.rst_n_out), 0);
                    check("drop_all_e3", int'(bus.all_released), 0);
                    check("drop_state_e3", int'(bus.seq_state), 0);
                    check("drop_events_e3", int'(bus.reset_events), 1);
                end
                4:  check("drop_state_e4", int'(bus.seq_state), 1);
                11: check("drop_out_e11", int'(bus.rst_n_out), 0);
                12: check("drop_out_e12", int'(bus.rst_n_out), 1);
                20: begin
                    check("drop_out_e20", int'(bus.rst_n_out), 7);
                    check("drop_all_e20", int'(bus.all_released), 1);
                end
                default: ;
            endcase
        end

        // pll_locked glitch after 5 WAIT_STABLE cycles restarts the stable count
        do_reset(1'b1, 1'b0);
        bus.pll_locked = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            step();
            if (n == 6) bus.pll_locked = 1'b0;
            if (n == 7) bus.pll_locked = 1'b1;
            case (n)
                8: check("glitch_state_e8", int'(bus.seq_state), 1);
                9: begin
                    check("glitch_state_e9", int'(bus.seq_state), 0);
                    check("glitch_events_e9", int'(bus.reset_events), 1);
                end
                10: check("glitch_state_e10", int'(bus.seq_state), 1);
                13: check("glitch_out_e13", int'(bus.rst_n_out), 0);
                17: check("glitch_out_e17", int'(bus.rst_n_out), 0);
                18: check("glitch_out_e18", int'(bus.rst_n_out), 1);
                26: begin
                    check("glitch_out_e26", int'(bus.rst_n_out), 7);
                    check("glitch_events_e26", int'(bus.reset_events), 1);
                end
                default: ;
            endcase
        end

        // Drop during RELEASE: abort lands on the edge stage 1 would have released
        do_reset(1'b1, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 12) bus.h2f_rst_n = 1'b0;
            if (n == 16) bus.h2f_rst_n = 1'b1;
            case (n)
                12: begin
                    check("rel_out_e12", int'(bus.rst_n_out), 1);
                    check("rel_state_e12", int'(bus.seq_state), 2);
                end
                14: check("rel_out_e14", int'(bus.rst_n_out), 1);
                15: begin
                    check("rel_out_e15", int'(bus.rst_n_out), 0);
                    check("rel_state_e15", int'(bus.seq_state), 0);
                    check("rel_events_e15", int'(bus.reset_events), 1);
                end
                16: check("rel_out_e16", int'(bus.rst_n_out), 0);
                default: ;
            endcase
        end

        // 300 drop/restore cycles saturate the event counter
        for (int k = 0; k < 300; k++) begin
            bus.h2f_rst_n = 1'b1;
            repeat (3) step();
            bus.h2f_rst_n = 1'b0;
            repeat (3) step();
        end
        repeat (4) step();
        check("sat_events", int'(bus.reset_events), 255);
        check("sat_state", int'(bus.seq_state), 0);

        // Asynchronous reset in the middle of RELEASE
        bus.h2f_rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.rst_n_out == 3'b011) found = 1'b1;
        end
        check("mid_reach_release", int'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_out", int'(bus.rst_n_out), 0);
        check("mid_all", int'(bus.all_released), 0);
        check("mid_state", int'(bus.seq_state), 0);
        check("mid_events", int'(bus.reset_events), 0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
